// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer that owns the PC and IR.
// Optional fetch watchdog is enabled by defining SEQ_WATCHDOG_EN.
module instr_sequencer #(
    parameter int PC_W          = 8,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [15:0]     imem_rdata,
    output logic [3:0]      op,
    output logic [3:0]      rs,
    output logic [3:0]      rt,
    output logic [3:0]      rd_imm,
    input  logic            ctrl_reg_write,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal_op,
    output logic            err_timeout,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic        fetch_done;
    logic        timeout_hit;
    logic        set_illegal;

    assign fetch_done = (state == FETCH) && imem_ready;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(FETCH_TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    // Counts consecutive FETCH cycles without ready; a same-cycle ready beats expiry.
    assign timeout_hit = (state == FETCH) && !imem_ready &&
                         (wd_cnt == WD_W'(FETCH_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == FETCH && !imem_ready)
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;
            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^FETCH_TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        case (state)
            IDLE: begin
                if (run)
                    state_next = FETCH;
            end
            FETCH: begin
                if (imem_ready)
                    state_next = DECODE;
                else if (timeout_hit)
                    state_next = HALT;
            end
            DECODE: begin
                if (!ir[15]) begin
                    state_next = EXECUTE;
                end else begin
                    state_next  = HALT;
                    set_illegal = (ir[15:12] != 4'hF);
                end
            end
            EXECUTE:   state_next = WRITEBACK;
            WRITEBACK: state_next = run ? FETCH : IDLE;
            HALT:      state_next = HALT;
            default:   state_next = IDLE;
        endcase
    end

    // Only WRITEBACK retires an instruction; halting ones leave pc and count alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
            illegal_op  <= 1'b0;
        end else begin
            state <= state_next;
            if (fetch_done)
                ir <= imem_rdata;
            if (set_illegal)
                illegal_op <= 1'b1;
            if (state == WRITEBACK) begin
                pc <= pc + PC_W'(1);
                if (instr_count != 16'hFFFF)
                    instr_count <= instr_count + 16'd1;
            end
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign rf_we     = (state == WRITEBACK) && ctrl_reg_write;
    assign busy      = (state != IDLE) && (state != HALT);
    assign halted    = (state == HALT);
    assign op        = ir[15:12];
    assign rs        = ir[11:8];
    assign rt        = ir[7:4];
    assign rd_imm    = ir[3:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer with a small instruction-memory model.
// Checks the SEQ_WATCHDOG_EN timeout only when that macro is defined.
module tb_instr_sequencer;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [3:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd_imm;
    logic        ctrl_reg_write;
    logic        rf_we;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        illegal_op;
    logic        err_timeout;
    logic [15:0] instr_count;

    int tests_run = 0;
    int fails     = 0;

    logic [15:0] mem [256];
    logic        mem_en;
    int          wait_target;
    int          wait_seen;

    instr_sequencer #(.PC_W(8), .FETCH_TIMEOUT(15)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .run(run),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .op(op),
        .rs(rs),
        .rt(rt),
        .rd_imm(rd_imm),
        .ctrl_reg_write(ctrl_reg_write),
        .rf_we(rf_we),
        .pc(pc),
        .busy(busy),
        .halted(halted),
        .illegal_op(illegal_op),
        .err_timeout(err_timeout),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after wait_target request cycles, or never when mem_en is low.
    assign imem_ready = mem_en && imem_req && (wait_seen >= wait_target);
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (!imem_req || imem_ready)
            wait_seen <= 0;
        else
            wait_seen <= wait_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        run            = 1'b0;
        ctrl_reg_write = 1'b1;
        mem_en         = 1'b1;
        wait_target    = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0123;
        do_reset();
        tests_run++;
        if ({imem_req, rf_we, busy, halted, illegal_op, err_timeout} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_strobes: got %b, want 000000",
                     {imem_req, rf_we, busy, halted, illegal_op, err_timeout});
        end
        tests_run++;
        if ({pc, op, rs, rt, rd_imm, instr_count} !== 40'h0) begin
            fails++;
            $display("[TB] FAIL reset_regs: pc=%h ir=%h%h%h%h cnt=%h, want all 0",
                     pc, op, rs, rt, rd_imm, instr_count);
        end
    endtask

    task automatic test_basic_add();
        do_reset();
        mem[0] = 16'h0123;
        run    = 1'b1;
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL add_fetch: req=%b addr=%h busy=%b, want 1 00 1", imem_req, imem_addr, busy);
        end
        tick();
        tests_run++;
        if ({op, rs, rt, rd_imm} !== 16'h0123 || rf_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL add_decode: fields=%h%h%h%h we=%b, want 0123 0", op, rs, rt, rd_imm, rf_we);
        end
        tick();
        tests_run++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL add_exec_we: got %b, want 0", rf_we);
        end
        tick();
        tests_run++;
        if (rf_we !== 1'b1) begin
            fails++;
            $display("[TB] FAIL add_wb_we: got %b, want 1", rf_we);
        end
        run = 1'b0;
        tick();
        tests_run++;
        if (pc !== 8'h01 || instr_count !== 16'd1 || rf_we !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL add_retire: pc=%h cnt=%0d we=%b busy=%b, want 01 1 0 0",
                     pc, instr_count, rf_we, busy);
        end
    endtask

    task automatic test_wait_states();
        int bad_req;
        do_reset();
        mem[0]      = 16'h0456;
        wait_target = 3;
        run         = 1'b1;
        bad_req     = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (imem_req !== 1'b1 || imem_addr !== 8'h00) bad_req++;
            if (i < 4 && rs !== 4'h0) bad_req++;
        end
        tests_run++;
        if (bad_req !== 0) begin
            fails++;
            $display("[TB] FAIL wait_req_hold: %0d bad cycles, want 0", bad_req);
        end
        tick();
        tests_run++;
        if (imem_req !== 1'b0 || rs !== 4'h4 || rf_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wait_decode: req=%b rs=%h we=%b, want 0 4 0", imem_req, rs, rf_we);
        end
        mem[0] = 16'h0999;
        tick();
        tick();
        tests_run++;
        if (rf_we !== 1'b1 || rs !== 4'h4 || rt !== 4'h5) begin
            fails++;
            $display("[TB] FAIL wait_wb_cycle7: we=%b rs=%h rt=%h, want 1 4 5", rf_we, rs, rt);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_illegal_halt();
        int bad;
        do_reset();
        mem[0] = 16'h9000;
        run    = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if (halted !== 1'b1 || illegal_op !== 1'b1 || busy !== 1'b0 || pc !== 8'h00 ||
            instr_count !== 16'd0 || imem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_halt: halt=%b ill=%b busy=%b pc=%h cnt=%0d req=%b, want 1 1 0 00 0 0",
                     halted, illegal_op, busy, pc, instr_count, imem_req);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            tick();
            if (halted !== 1'b1 || rf_we !== 1'b0 || imem_req !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            fails++;
            $display("[TB] FAIL halt_sticky: %0d bad cycles, want 0", bad);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (halted !== 1'b0 || illegal_op !== 1'b0) begin
            fails++;
            $display("[TB] FAIL halt_reset: halt=%b ill=%b, want 0 0", halted, illegal_op);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_clean_halt();
        do_reset();
        mem[0] = 16'hF000;
        run    = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if (halted !== 1'b1 || illegal_op !== 1'b0 || pc !== 8'h00) begin
            fails++;
            $display("[TB] FAIL clean_halt: halt=%b ill=%b pc=%h, want 1 0 00", halted, illegal_op, pc);
        end
        mem[0] = 16'h0123;
    endtask

    task automatic test_pc_wrap();
        int pulses;
        do_reset();
        run    = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            if (rf_we === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 256 || pc !== 8'hFF) begin
            fails++;
            $display("[TB] FAIL wrap_pre: pulses=%0d pc=%h, want 256 ff", pulses, pc);
        end
        tick();
        tests_run++;
        if (pc !== 8'h00 || imem_addr !== 8'h00 || imem_req !== 1'b1 || instr_count !== 16'd256) begin
            fails++;
            $display("[TB] FAIL wrap_post: pc=%h addr=%h req=%b cnt=%0d, want 00 00 1 256",
                     pc, imem_addr, imem_req, instr_count);
        end
        run = 1'b0;
        tick();
        tick();
        tick();
        tick();
    endtask

    task automatic test_run_drop();
        do_reset();
        mem[0] = 16'h0123;
        mem[1] = 16'h1456;
        run    = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        tests_run++;
        if (rf_we !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL drop_wb: we=%b busy=%b, want 1 1", rf_we, busy);
        end
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h01 || rf_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL drop_idle: busy=%b req=%b pc=%h we=%b, want 0 0 01 0", busy, imem_req, pc, rf_we);
        end
        run = 1'b1;
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
            fails++;
            $display("[TB] FAIL drop_resume: req=%b addr=%h, want 1 01", imem_req, imem_addr);
        end
        tick();
        tests_run++;
        if (op !== 4'h1 || rs !== 4'h4) begin
            fails++;
            $display("[TB] FAIL drop_decode: op=%h rs=%h, want 1 4", op, rs);
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (rf_we !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || instr_count !== 16'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid: we=%b busy=%b pc=%h cnt=%0d, want 0 0 00 0", rf_we, busy, pc, instr_count);
        end
        run     = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch_stall();
        do_reset();
        mem_en = 1'b0;
        run    = 1'b1;
`ifdef SEQ_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick();
        tests_run++;
        if (imem_req !== 1'b1 || halted !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wd_before: req=%b halt=%b, want 1 0", imem_req, halted);
        end
        tick();
        tests_run++;
        if (halted !== 1'b1 || err_timeout !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wd_expire: halt=%b err=%b req=%b, want 1 1 0", halted, err_timeout, imem_req);
        end
`else
        for (int i = 0; i < 1000; i++) tick();
        tests_run++;
        if (imem_req !== 1'b1 || busy !== 1'b1 || halted !== 1'b0 || err_timeout !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stall_wait: req=%b busy=%b halt=%b err=%b, want 1 1 0 0",
                     imem_req, busy, halted, err_timeout);
        end
`endif
        mem_en = 1'b1;
        run    = 1'b0;
    endtask

    initial begin
        wait_seen = 0;
        test_reset();
        test_basic_add();
        test_wait_states();
        test_illegal_halt();
        test_clean_halt();
        test_pc_wrap();
        test_run_drop();
        test_reset_mid();
        test_fetch_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the simplified MIPS machine. It owns the program counter and the instruction register, and fetches 16-bit instructions over a request/ready handshake. It decodes the 4-bit op and operand fields that feed the control unit and register file, and qualifies the control unit's RegWrite into a single-cycle register-file write strobe. It sits between instruction memory and the existing control unit/ALU/register-file datapath and sequences one instruction at a time.

## Interface
- PC_W, 8, program-counter/instruction-address width
- FETCH_TIMEOUT, 15, watchdog limit in cycles; only used with SEQ_WATCHDOG_EN
- clk  in  1  clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ready  in  1  memory has valid data this cycle
- imem_rdata  in  16  instruction word
- op  out  4  ir[15:12], to control unit Op
- rs  out  4  ir[11:8]
- rt  out  4  ir[7:4]
- rd_imm  out  4  ir[3:0]; destination register or load-immediate value
- ctrl_reg_write  in  1  RegWrite from control unit
- rf_we  out  1  register-file write strobe
- pc  out  PC_W  current program counter
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- illegal_op  out  1  sticky; set when HALT is entered on an undefined op
- err_timeout  out  1  sticky; fetch watchdog expired
- instr_count  out  16  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: all strobes low. run=1 → FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, held until imem_ready.
  - On the edge where imem_req & imem_ready, ir ← imem_rdata, then → DECODE.
  - imem_ready while not in FETCH is ignored.
- DECODE:
  - op 0000–0111 → EXECUTE.
  - op 1111 → HALT (clean halt; illegal_op stays 0).
  - op 1000–1110 → HALT with illegal_op=1.
- EXECUTE: one cycle; fields held stable so the ALU result settles. → WRITEBACK.
- WRITEBACK:
  - rf_we = ctrl_reg_write, combinational, this cycle only.
  - pc ← pc+1, wrapping modulo 2^PC_W (all-ones → 0).
  - instr_count ← instr_count+1, saturating at 0xFFFF.
  - run=1 → FETCH; run=0 → IDLE.
- HALT: terminal; only reset_n leaves it. run is ignored.
- run deasserted mid-instruction: the current instruction completes through WRITEBACK, then → IDLE. No instruction is aborted.
- op/rs/rt/rd_imm always reflect ir, including while IDLE.
- Halting instructions do not retire: pc and instr_count are unchanged on entering HALT.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert use):
  - State = IDLE.
  - pc=0, ir=0 (so op/rs/rt/rd_imm=0).
  - imem_req=0, rf_we=0, busy=0, halted=0, illegal_op=0, err_timeout=0, instr_count=0.
  - Reset asserted mid-instruction abandons it immediately; no rf_we is emitted.
- Minimum of 4 cycles per instruction (FETCH with same-cycle ready, DECODE, EXECUTE, WRITEBACK). Each wait cycle in FETCH adds 1.
- rf_we is high for exactly 1 cycle per retired instruction with ctrl_reg_write=1, and never outside WRITEBACK.
- From run rising in IDLE, imem_req asserts on the next cycle.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A cycle counter runs while in FETCH without imem_ready and clears on FETCH entry.
  - When the count reaches FETCH_TIMEOUT with still no ready, → HALT with err_timeout=1, and imem_req drops.
  - If ready arrives in the same cycle the count reaches the limit, ready wins.
- SEQ_WATCHDOG_EN undefined: FETCH waits indefinitely, the counter is absent, and err_timeout is tied to 0.

## Test plan
- Reset, run=1, memory returns 0x0123 (add) with ready on the first request cycle, ctrl_reg_write=1 → op=0, rs=1, rt=2, rd_imm=3; rf_we pulses once in cycle 4; pc=1; instr_count=1.
- Memory inserts 3 wait cycles → imem_req held 4 cycles with imem_addr constant; rf_we occurs in cycle 7; no double latch of ir.
- Fetch 0x9000 → HALT, illegal_op=1, halted=1, pc unchanged, no rf_we; run toggling has no effect until reset_n low.
- Start from pc=0xFF (PC_W=8) with run held → after WRITEBACK pc=0x00; fetch at address 0x00 follows.
- run dropped during EXECUTE → WRITEBACK completes (rf_we if ctrl_reg_write=1), then IDLE with busy=0; reasserting run resumes at the next pc.
- With SEQ_WATCHDOG_EN, FETCH_TIMEOUT=15, ready never asserted → HALT with err_timeout=1 after 15 FETCH cycles. Without the macro, the bench still waits in FETCH after 1000 cycles and err_timeout=0.
